// File: rtl/piso_pkg.sv
// PISO shared constants and helpers.
// Default width and the bit-counter width function.
package piso_pkg;

  localparam int PISO_DEF_WIDTH = 4;

  function automatic int piso_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// PISO bit counter: counts the remaining bits of the loaded word.
// The valid flag is high while bits remain.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEF_WIDTH,
  localparam int CW = piso_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  output logic [CW-1:0] cnt,
  output logic          valid
);

  logic [CW-1:0] r_cnt;

  // Saturates at zero so an idle line never wraps back to valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign cnt   = r_cnt;
  assign valid = (r_cnt != '0);

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out shift register, MSB first by default.
// Define PISO_LSB_FIRST_EN for LSB-first shifting.
module piso
  import piso_pkg::*;
#(
  parameter int   WIDTH = PISO_DEF_WIDTH,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             load,
  output logic             so,
  output logic             so_valid
);

  localparam int CW = piso_cnt_w(WIDTH);

  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    w_unused_cnt;
  logic             w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= pi;
    end else begin
`ifdef PISO_LSB_FIRST_EN
      r_sreg <= {FILL, r_sreg[WIDTH-1:1]};
`else
      r_sreg <= {r_sreg[WIDTH-2:0], FILL};
`endif
    end
  end

`ifdef PISO_LSB_FIRST_EN
  assign so = r_sreg[0];
`else
  assign so = r_sreg[WIDTH-1];
`endif

  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .cnt   (w_unused_cnt),
    .valid (w_valid)
  );

  assign so_valid = w_valid;

endmodule

// File: tb/tb_piso.sv
// Directed self-checking bench for piso (4-bit FILL=0 and 8-bit FILL=1).
// Bit order follows PISO_LSB_FIRST_EN when defined.
module tb_piso;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pi4;
  logic       load4;
  logic       so4, vld4;
  logic [7:0] pi8;
  logic       load8;
  logic       so8, vld8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(4), .FILL(1'b0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pi(pi4), .load(load4),
    .so(so4), .so_valid(vld4)
  );

  piso #(.WIDTH(8), .FILL(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .pi(pi8), .load(load8),
    .so(so8), .so_valid(vld8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [31:0] w,
                                  input int width, input int i);
`ifdef PISO_LSB_FIRST_EN
    return w[i];
`else
    return w[width-1-i];
`endif
  endfunction

  // Load on the coming edge, then check n serial bits.
  task automatic run4(input string tag, input logic [3:0] w,
                      input int n);
    load4 = 1'b1;
    pi4   = w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) load4 = 1'b0;
      chk($sformatf("%s.so%0d", tag, i), 32'(so4),
          32'(bit_at(32'(w), 4, i)));
      chk($sformatf("%s.v%0d", tag, i), 32'(vld4), 32'd1);
    end
  endtask

  task automatic idle4(input string tag);
    @(negedge clk);
    chk({tag, ".so"}, 32'(so4), 32'd0);
    chk({tag, ".v"}, 32'(vld4), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load4 = 1'b1;
    pi4   = 4'hF;
    load8 = 1'b1;
    pi8   = 8'hFF;
    #3;
    chk("rst.so4", 32'(so4), 32'd0);
    chk("rst.v4", 32'(vld4), 32'd0);
    chk("rst.so8", 32'(so8), 32'd0);
    chk("rst.v8", 32'(vld8), 32'd0);
    // Load held during reset must be ignored across edges.
    repeat (2) @(negedge clk);
    chk("rstld.so4", 32'(so4), 32'd0);
    chk("rstld.v4", 32'(vld4), 32'd0);
    load4 = 1'b0;
    load8 = 1'b0;
    rst_n = 1'b1;
    idle4("post_rst");

    run4("w1010", 4'b1010, 4);
    idle4("w1010.end");
    idle4("w1010.end2");

    run4("w1101", 4'b1101, 4);
    idle4("w1101.end");

    run4("mid1010", 4'b1010, 2);
    run4("mid0110", 4'b0110, 4);
    idle4("mid.end");

    // Continuous load: each cycle shows the first bit of current pi.
    load4 = 1'b1;
    pi4   = 4'b1000;
    @(negedge clk);
    chk("hold.a", 32'(so4), 32'(bit_at(32'h8, 4, 0)));
    pi4 = 4'b0001;
    @(negedge clk);
    chk("hold.b", 32'(so4), 32'(bit_at(32'h1, 4, 0)));
    chk("hold.bv", 32'(vld4), 32'd1);
    pi4 = 4'b0110;
    @(negedge clk);
    chk("hold.c", 32'(so4), 32'd0);
    load4 = 1'b0;

    // Asynchronous reset mid-word, away from any edge.
    run4("ar", 4'b1111, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.so", 32'(so4), 32'd0);
    chk("ar.v", 32'(vld4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle4("ar.after");

    // 8-bit, FILL=1: zeros for eight cycles then the fill value.
    load8 = 1'b1;
    pi8   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load8 = 1'b0;
      chk($sformatf("f8.so%0d", i), 32'(so8), 32'd0);
      chk($sformatf("f8.v%0d", i), 32'(vld8), 32'd1);
    end
    @(negedge clk);
    chk("f8.end.so", 32'(so8), 32'd1);
    chk("f8.end.v", 32'(vld8), 32'd0);

    // 8-bit data word 8'hA5 = 1010_0101.
    load8 = 1'b1;
    pi8   = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load8 = 1'b0;
      chk($sformatf("a5.so%0d", i), 32'(so8),
          32'(bit_at(32'hA5, 8, i)));
    end
    @(negedge clk);
    chk("a5.end.so", 32'(so8), 32'd1);
    chk("a5.end.v", 32'(vld8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter WIDTH, default 4, number of parallel bits per word; legal range 2..32.
REQ-002 Parameter FILL, default 1'b0, bit value shifted into the vacated register position on each shift.
REQ-003 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port pi, input, WIDTH, parallel data word, sampled only on a load edge.
REQ-006 Port load, input, 1, load strobe; high at a rising edge captures pi, low shifts.
REQ-007 Port so, output, 1, serial data out, taken directly from the register output bit (no combinational path from inputs).
REQ-008 Port so_valid, output, 1, high while so carries a bit of the last loaded word.

Function
REQ-009 The block SHALL hold a WIDTH-bit shift register sreg and a bit counter cnt of width $clog2(WIDTH+1).
REQ-010 When load=1 at a rising edge, the block SHALL set sreg<=pi and cnt<=WIDTH, regardless of current cnt.
REQ-011 When load=0 at a rising edge, the block SHALL shift sreg one position toward the output end and insert FILL at the far end.
REQ-012 When load=0 at a rising edge and cnt>0, the block SHALL decrement cnt; at cnt=0 it SHALL hold cnt at 0 with no wrap-around.
REQ-013 In default (MSB-first) mode, so SHALL equal sreg[WIDTH-1] and the shift SHALL be sreg<={sreg[WIDTH-2:0],FILL}.
REQ-014 so_valid SHALL equal (cnt!=0).
REQ-015 The first bit SHALL appear on so in the cycle immediately after the load edge (zero extra latency); a word SHALL occupy exactly WIDTH consecutive cycles when load stays low.
REQ-016 A load asserted mid-word SHALL abort the current word, and the new word's first bit SHALL appear on so after that edge.
REQ-017 After the final bit, so SHALL output FILL and so_valid SHALL be 0 until the next load.
REQ-018 load held high continuously SHALL reload each cycle, so so SHALL present the current pi's first bit each cycle.

Reset
REQ-019 rst_n=0 SHALL immediately clear sreg and cnt to 0, so so=0 and so_valid=0, independent of clk.
REQ-020 load SHALL be ignored while rst_n=0; the first edge after deassertion SHALL behave per REQ-010/011.
REQ-021 Reset SHALL be accepted mid-word and SHALL discard remaining bits.

Configuration
REQ-022 Macro PISO_LSB_FIRST_EN: when defined, so SHALL equal sreg[0] and the shift SHALL be sreg<={FILL,sreg[WIDTH-1:1]} (LSB first); when undefined, MSB-first per REQ-013. Counter and valid behaviour SHALL be identical in both modes.

Structure
REQ-023 Package piso_pkg SHALL hold the default width constant (4) and a cnt-width helper function.
REQ-024 The bit counter and so_valid SHALL be a sub-module piso_bit_cnt (inputs clk, rst_n, load, WIDTH; outputs cnt, valid); the shift register SHALL stay in piso.

Verification
REQ-025 Reset: rst_n=0 asynchronously mid-cycle -> so=0 and so_valid=0 immediately.
REQ-026 MSB-first: load=1, pi=4'b1010 for one edge, then load=0 -> so sequence 1,0,1,0 with so_valid=1, then so=0 with so_valid=0.
REQ-027 Back-to-back: after pi=1010 fully shifted, load pi=4'b1101 -> so 1,1,0,1, then 0 with so_valid=0.
REQ-028 Mid-word reload: load 1010, shift two bits (1,0), then load 0110 -> so 0,1,1,0 with so_valid high for 4 cycles.
REQ-029 With PISO_LSB_FIRST_EN: load 4'b1101 -> so 1,0,1,1.
REQ-030 FILL=1, WIDTH=8: load 8'h00 -> so 0 for 8 cycles with so_valid=1, then so=1 with so_valid=0.
